fdiv_iter: RTL and testbench

- Parametrised, multi-cycle IEEE-754-style floating-point divider with valid/ready handshakes on input and output.
- Successor to the fixed single-precision fdiv: operand format is generic (EXP_W/MAN_W), quotient bits per cycle are configurable, results have full special-case handling, and latency is fixed.
- Sits in the FPU beside fmul/fadd and is driven by the core's FP issue logic.

---
 rtl/fdiv_iter.sv | 254 +++++++++++++++++++++++++
 tb/tb_fdiv_iter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_iter.sv
// ---------------------------------------------------------------------------
// fdiv_iter -- parametrised multi-cycle floating-point divider
//
// Divides x1 by x2 in an IEEE-754-style format with EXP_W exponent bits and
// MAN_W stored mantissa bits. A restoring divider retires BITS_PER_CYCLE
// quotient bits per clock. The latency is fixed: out_valid rises ITER+1
// edges after the operands are accepted, where
// ITER = ceil((MAN_W+2)/BITS_PER_CYCLE). Subnormals are flushed to zero.
// NaN, infinity and zero operands produce the usual special results.
//
// Optional feature (compile-time macro):
//   FDIV_ROUND_NEAREST_EN  defined   -> round to nearest, ties to even
//                          undefined -> truncate toward zero
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   operands present
//   in_ready   out  block can accept operands (high only when idle)
//   x1         in   dividend, 1+EXP_W+MAN_W bits
//   x2         in   divisor,  1+EXP_W+MAN_W bits
//   out_valid  out  quotient y valid
//   out_ready  in   consumer accepts y
//   y          out  quotient x1/x2, held after the handshake
// ---------------------------------------------------------------------------
module fdiv_iter #(
    parameter int EXP_W          = 8,
    parameter int MAN_W          = 23,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   x1,
    input  logic [EXP_W+MAN_W:0]   x2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y
);

    // Quotient bits kept: leading 1, MAN_W mantissa bits, one guard bit.
    localparam int QW      = MAN_W + 2;
    localparam int ITER    = (QW + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam int QTOT    = ITER * BITS_PER_CYCLE;
    localparam int SURPLUS = QTOT - QW;
    localparam int CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;

`ifdef FDIV_ROUND_NEAREST_EN
    localparam bit ROUND_NEAREST = 1'b1;
`else
    localparam bit ROUND_NEAREST = 1'b0;
`endif

    // Selects the quotient bits that fall below the guard bit.
    localparam logic [QTOT-1:0] SUR_MASK = QTOT'((64'd1 << SURPLUS) - 64'd1);

    localparam logic signed [EXP_W+1:0] BIAS_S   = (EXP_W+2)'((1 << (EXP_W-1)) - 1);
    localparam logic signed [EXP_W+1:0] EXP_INF  = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
    localparam logic [EXP_W-1:0]        EXP_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        PACK = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   accept;
    logic   pack;

    logic [CNT_W-1:0] cnt;

    // Rounding of the kept significand. In truncate builds the increment is
    // constant zero and the guard/sticky logic is optimised away.
    function automatic logic [MAN_W+1:0] round_sig(
        input logic [MAN_W:0] sig,
        input logic           guard,
        input logic           sticky
    );
        logic inc;
        inc = ROUND_NEAREST & guard & (sticky | sig[0]);
        return {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
    endfunction

    // Operand fields and classification at the input
    logic [EXP_W-1:0] ea_in, eb_in;
    logic [MAN_W:0]   ma_in, mb_in;
    logic             a_zero_in, a_inf_in, a_nan_in;
    logic             b_zero_in, b_inf_in, b_nan_in;

    assign ea_in     = x1[EXP_W+MAN_W-1:MAN_W];
    assign eb_in     = x2[EXP_W+MAN_W-1:MAN_W];
    assign ma_in     = {1'b1, x1[MAN_W-1:0]};
    assign mb_in     = {1'b1, x2[MAN_W-1:0]};
    assign a_zero_in = (ea_in == '0);
    assign b_zero_in = (eb_in == '0);
    assign a_inf_in  = (ea_in == EXP_ONES) && (x1[MAN_W-1:0] == '0);
    assign b_inf_in  = (eb_in == EXP_ONES) && (x2[MAN_W-1:0] == '0);
    assign a_nan_in  = (ea_in == EXP_ONES) && (x1[MAN_W-1:0] != '0);
    assign b_nan_in  = (eb_in == EXP_ONES) && (x2[MAN_W-1:0] != '0);

    // Latched operation context
    logic             sign_r;
    logic             exp_adj_r;
    logic [EXP_W-1:0] ea_r, eb_r;
    logic             a_zero_r, a_inf_r, a_nan_r;
    logic             b_zero_r, b_inf_r, b_nan_r;
    logic [MAN_W:0]   mb_r;
    logic [QW-1:0]    rem_r, rem_nx;
    logic [QTOT-1:0]  quo_r, quo_nx;

    // FSM state register and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt <= CNT_W'(ITER - 1);
            end else if (state == DIV && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        pack      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = DIV;
                end
            end
            DIV: begin
                if (cnt == '0) begin
                    state_nx = PACK;
                end
            end
            PACK: begin
                pack     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Restoring division: BITS_PER_CYCLE compare/subtract/shift steps.
    // The remainder stays below the divisor after each subtract, so the
    // left shift never loses a set bit.
    always_comb begin
        rem_nx = rem_r;
        quo_nx = quo_r;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (rem_nx >= {1'b0, mb_r}) begin
                rem_nx = rem_nx - {1'b0, mb_r};
                quo_nx = {quo_nx[QTOT-2:0], 1'b1};
            end else begin
                quo_nx = {quo_nx[QTOT-2:0], 1'b0};
            end
            rem_nx = rem_nx << 1;
        end
    end

    // Operand latch / iteration datapath (no reset: only meaningful
    // while the FSM is busy)
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_r   <= x1[EXP_W+MAN_W] ^ x2[EXP_W+MAN_W];
            ea_r     <= ea_in;
            eb_r     <= eb_in;
            a_zero_r <= a_zero_in;
            a_inf_r  <= a_inf_in;
            a_nan_r  <= a_nan_in;
            b_zero_r <= b_zero_in;
            b_inf_r  <= b_inf_in;
            b_nan_r  <= b_nan_in;
            mb_r     <= mb_in;
            quo_r    <= '0;
            // Pre-normalise so the first quotient bit is always 1.
            if (ma_in < mb_in) begin
                rem_r     <= {ma_in, 1'b0};
                exp_adj_r <= 1'b1;
            end else begin
                rem_r     <= {1'b0, ma_in};
                exp_adj_r <= 1'b0;
            end
        end else if (state == DIV) begin
            rem_r <= rem_nx;
            quo_r <= quo_nx;
        end
    end

    // Result assembly: rounding, exponent range and special cases
    logic [QW-1:0]             q_keep;
    logic                      sticky;
    logic [MAN_W+1:0]          rounded;
    logic                      carry;
    logic [MAN_W-1:0]          man_out;
    logic signed [EXP_W+1:0]   e_raw, e_fin;
    logic [EXP_W+MAN_W:0]      result;

    always_comb begin
        q_keep  = quo_r[QTOT-1:SURPLUS];
        sticky  = (rem_r != '0) || ((quo_r & SUR_MASK) != '0);
        rounded = round_sig(q_keep[QW-1:1], q_keep[0], sticky);
        carry   = rounded[MAN_W+1];
        // A carry out means the significand rounded up to 2.0.
        man_out = carry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
        e_raw   = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + BIAS_S
                  - $signed({{(EXP_W+1){1'b0}}, exp_adj_r});
        e_fin   = e_raw + $signed({{(EXP_W+1){1'b0}}, carry});

        if (a_nan_r || b_nan_r || (a_zero_r && b_zero_r) || (a_inf_r && b_inf_r)) begin
            result = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (a_inf_r || b_zero_r) begin
            result = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero_r || b_inf_r) begin
            result = {sign_r, {(EXP_W+MAN_W){1'b0}}};
        end else if (e_fin >= EXP_INF) begin
            result = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
        end else if (e_fin <= EXP_ZERO) begin
            result = {sign_r, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            result = {sign_r, e_fin[EXP_W-1:0], man_out};
        end
    end

    // Output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= '0;
        end else if (pack) begin
            y <= result;
        end
    end

endmodule

// File: tb/tb_fdiv_iter.sv
module tb_fdiv_iter;

    localparam int LAT0 = 26;   // BITS_PER_CYCLE = 1
    localparam int LAT1 = 14;   // BITS_PER_CYCLE = 2
`ifdef FDIV_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
    localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
    localparam bit RNE = 1'b0;
    localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [2];
    logic        ordy [2];
    logic [31:0] a_s  [2];
    logic [31:0] b_s  [2];
    logic        rdy0, rdy1, ov0, ov1;
    logic [31:0] y0, y1;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb0[$];
    logic [31:0] sb1[$];

    fdiv_iter #(.EXP_W(8), .MAN_W(23), .BITS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy0),
        .x1(a_s[0]), .x2(b_s[0]), .out_valid(ov0), .out_ready(ordy[0]), .y(y0)
    );

    fdiv_iter #(.EXP_W(8), .MAN_W(23), .BITS_PER_CYCLE(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy1),
        .x1(a_s[1]), .x2(b_s[1]), .out_valid(ov1), .out_ready(ordy[1]), .y(y1)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", name, got, want);
        end
    endtask

    task automatic check_true(input string name, input bit cond, input longint got, input longint want);
        total++;
        if (!cond) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic logic get_rdy(input int i);
        return (i == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic get_ov(input int i);
        return (i == 0) ? ov0 : ov1;
    endfunction

    // Behavioural quotient: exact integer division of the significands,
    // then the format's rounding, range and special-case rules.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s;
        logic [7:0] ea, eb;
        logic an, ai, az, bn, bi, bz;
        logic [63:0] ma, mb, num, q, r, mant;
        int e;
        logic g, st;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        an = (ea == 8'hFF) && (a[22:0] != 23'd0);
        ai = (ea == 8'hFF) && (a[22:0] == 23'd0);
        az = (ea == 8'h00);
        bn = (eb == 8'hFF) && (b[22:0] != 23'd0);
        bi = (eb == 8'hFF) && (b[22:0] == 23'd0);
        bz = (eb == 8'h00);
        if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC00000;
        if (ai || bz) return {s, 8'hFF, 23'd0};
        if (az || bi) return {s, 31'd0};
        ma = {40'd0, 1'b1, a[22:0]};
        mb = {40'd0, 1'b1, b[22:0]};
        e  = int'(ea) - int'(eb) + 127;
        if (ma >= mb) begin
            num = ma << 24;
        end else begin
            num = ma << 25;
            e   = e - 1;
        end
        q    = num / mb;
        r    = num % mb;
        g    = q[0];
        st   = (r != 64'd0);
        mant = q >> 1;
        if (RNE && g && (st || mant[0])) mant = mant + 64'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], mant[22:0]};
    endfunction

    // Independent reference for normal operands: double-precision division
    // rounded to single (round to nearest even).
    function automatic logic [31:0] real_ref(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] da, db, dq;
        real q;
        int e;
        logic [24:0] m;
        da = {a[31], 11'({3'b000, a[30:23]} + 11'd896), a[22:0], 29'd0};
        db = {b[31], 11'({3'b000, b[30:23]} + 11'd896), b[22:0], 29'd0};
        q  = $bitstoreal(da) / $bitstoreal(db);
        dq = $realtobits(q);
        e  = int'(dq[62:52]) - 1023 + 127;
        m  = {2'b01, dq[51:29]};
        if (dq[28] && ((|dq[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        return {dq[63], e[7:0], m[22:0]};
    endfunction

    // Compare process: every cycle a result is presented it must match the
    // oldest outstanding expectation for that divider.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov0) begin
                if (sb0.size() == 0) begin
                    check_true("dut0_spurious_valid", 1'b0, 1, 0);
                end else begin
                    check("dut0_y", y0, sb0[0]);
                    if (ordy[0]) void'(sb0.pop_front());
                end
            end
            if (ov1) begin
                if (sb1.size() == 0) begin
                    check_true("dut1_spurious_valid", 1'b0, 1, 0);
                end else begin
                    check("dut1_y", y1, sb1[0]);
                    if (ordy[1]) void'(sb1.pop_front());
                end
            end
        end
    end

    // Issue one division and wait for its result; checks latency and that
    // in_ready stays low while busy. Returns #1 after out_valid rises.
    task automatic send(input int i, input logic [31:0] a, input logic [31:0] b, input int lat);
        int n;
        bit busy_ok;
        n = 0;
        while (!get_rdy(i) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_true("in_ready_wait", n < 200, n, 0);
        if (i == 0) sb0.push_back(model(a, b));
        else        sb1.push_back(model(a, b));
        iv[i]  = 1'b1;
        a_s[i] = a;
        b_s[i] = b;
        @(posedge clk); #1;
        iv[i] = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        while (!get_ov(i) && n < 200) begin
            if (get_rdy(i)) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check_true("latency", n == lat, n, lat);
        check_true("in_ready_low_busy", busy_ok, 0, 1);
    endtask

    logic [31:0] ra, rb, mres, rref;
    int          d;
    bit          quiet;

    initial begin
        iv[0] = 1'b0; iv[1] = 1'b0;
        ordy[0] = 1'b1; ordy[1] = 1'b1;
        a_s[0] = '0; a_s[1] = '0; b_s[0] = '0; b_s[1] = '0;
        rst = 1'b1;
        #12;
        check_true("rst_in_ready0", rdy0 == 1'b1, rdy0, 1);
        check_true("rst_out_valid0", ov0 == 1'b0, ov0, 0);
        check("rst_y0", y0, 32'h0);
        check_true("rst_in_ready1", rdy1 == 1'b1, rdy1, 1);
        check_true("rst_out_valid1", ov1 == 1'b0, ov1, 0);
        check("rst_y1", y1, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed values with hand-computed results
        send(0, 32'h40C00000, 32'h40400000, LAT0);
        check("six_div_three", y0, 32'h40000000);
        send(0, 32'h3F800000, 32'h40400000, LAT0);
        check("one_div_three", y0, ONE_THIRD);
        send(0, 32'h3F800000, 32'h00000000, LAT0);
        check("one_div_zero", y0, 32'h7F800000);
        send(0, 32'h00000000, 32'h00000000, LAT0);
        check("zero_div_zero", y0, 32'h7FC00000);
        send(0, 32'hBF800000, 32'h7F800000, LAT0);
        check("neg_div_inf", y0, 32'h80000000);
        send(0, 32'h7F7FFFFF, 32'h00800000, LAT0);
        check("overflow_inf", y0, 32'h7F800000);
        send(0, 32'h7FC00001, 32'h3F800000, LAT0);
        check("nan_operand", y0, 32'h7FC00000);
        send(0, 32'hFF800000, 32'h7F800000, LAT0);
        check("inf_div_inf", y0, 32'h7FC00000);
        send(0, 32'h00800000, 32'h7F000000, LAT0);
        check("underflow_zero", y0, 32'h00000000);
        send(1, 32'h40C00000, 32'h40400000, LAT1);
        check("six_div_three_b2", y1, 32'h40000000);
        send(1, 32'hC0400000, 32'h3F800000, LAT1);
        check("neg_three_b2", y1, 32'hC0400000);

        // Backpressure: result held, new operands ignored
        ordy[0] = 1'b0;
        send(0, 32'h40400000, 32'h3F800000, LAT0);
        for (int k = 0; k < 10; k++) begin
            iv[0]  = 1'b1;
            a_s[0] = 32'h3F800000;
            b_s[0] = 32'h40000000;
            @(posedge clk); #1;
            check_true("bp_out_valid", ov0 == 1'b1, ov0, 1);
            check("bp_y", y0, 32'h40400000);
            check_true("bp_in_ready", rdy0 == 1'b0, rdy0, 0);
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        check_true("bp_release_ready", rdy0 == 1'b1, rdy0, 1);
        check_true("bp_release_valid", ov0 == 1'b0, ov0, 0);
        check("bp_y_after", y0, 32'h40400000);
        quiet = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (ov0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        check_true("bp_ignored_input", quiet, 0, 1);

        // Reset in the middle of an operation
        iv[0]  = 1'b1;
        a_s[0] = 32'h3F800000;
        b_s[0] = 32'h40400000;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_true("midrst_out_valid", ov0 == 1'b0, ov0, 0);
        check("midrst_y", y0, 32'h0);
        check_true("midrst_in_ready", rdy0 == 1'b1, rdy0, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (ov0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        check_true("midrst_no_result", quiet, 0, 1);
        send(0, 32'h40C00000, 32'h40400000, LAT0);
        check("after_rst_result", y0, 32'h40000000);

        // Random normal positive operands on both dividers
        for (int k = 0; k < 500; k++) begin
            ra   = {1'b0, 8'(80 + $urandom_range(0, 95)), 23'($urandom)};
            rb   = {1'b0, 8'(80 + $urandom_range(0, 95)), 23'($urandom)};
            mres = model(ra, rb);
            rref = real_ref(ra, rb);
            d    = int'(rref) - int'(mres);
            if (d < 0) d = -d;
            if (RNE) check("model_vs_real", mres, rref);
            else     check_true("model_vs_real_ulp", d <= 1, d, 1);
            send(0, ra, rb, LAT0);
            send(1, ra, rb, LAT1);
        end

        repeat (5) @(posedge clk);
        #1;
        check_true("sb0_drained", sb0.size() == 0, sb0.size(), 0);
        check_true("sb1_drained", sb1.size() == 0, sb1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
